// File: rtl/vxe_txn_pkg.sv
// Shared widths and field layout for the VxE request-transaction vectors.
// The txn vector is {txnid, rnw, addr} with addr in the low bits.
package vxe_txn_pkg;

  localparam int TXNID_W_DEF = 6;
  localparam int ADDR_W_DEF  = 37;
  localparam int DATA_W_DEF  = 64;

  function automatic int txn_w(input int txnid_w, input int addr_w);
    return txnid_w + 1 + addr_w;
  endfunction

  function automatic int dat_w(input int data_w);
    return data_w / 8 + data_w;
  endfunction

  function automatic int rnw_pos(input int addr_w);
    return addr_w;
  endfunction

  function automatic int txnid_lsb(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/vxe_txnreq_rr_arb.sv
// NCH-way round-robin arbiter; ptr names the highest-priority channel and
// moves just past the winner whenever the grant is actually taken (i_adv).
module vxe_txnreq_rr_arb
  import vxe_txn_pkg::*;
#(
  parameter int NCH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         i_req,
  input  logic                   i_adv,
  output logic [NCH-1:0]         o_grant,
  output logic [ch_w(NCH)-1:0]   o_gidx
);

  localparam int IW = ch_w(NCH);

  logic [IW-1:0] ptr;
  logic          found;

  // Two passes avoid modulo indexing: channels at/after ptr first, then the wrap.
  always_comb begin
    o_grant = '0;
    o_gidx  = '0;
    found   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (!found && (c >= int'(ptr)) && i_req[c]) begin
        found      = 1'b1;
        o_grant[c] = 1'b1;
        o_gidx     = IW'(c);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (!found && (c < int'(ptr)) && i_req[c]) begin
        found      = 1'b1;
        o_grant[c] = 1'b1;
        o_gidx     = IW'(c);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (i_adv) begin
      ptr <= (o_gidx == IW'(NCH - 1)) ? '0 : o_gidx + 1'b1;
    end
  end

endmodule

// File: rtl/vxe_txnreq_mux_coder.sv
// Merges NCH request channels through a round-robin arbiter, encodes the
// winner into txn/dat vectors and buffers them in a DEPTH-entry FIFO.
module vxe_txnreq_mux_coder
  import vxe_txn_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int TXNID_W = TXNID_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NCH-1:0]                      i_vld,
  output logic [NCH-1:0]                      o_rdy,
  input  logic [NCH*TXNID_W-1:0]              i_txnid,
  input  logic [NCH-1:0]                      i_rnw,
  input  logic [NCH*ADDR_W-1:0]               i_addr,
  input  logic [NCH*DATA_W-1:0]               i_data,
  input  logic [NCH*(DATA_W/8)-1:0]           i_ben,
  output logic                                o_vld,
  input  logic                                i_rdy,
  output logic [txn_w(TXNID_W, ADDR_W)-1:0]   o_req_vec_txn,
  output logic [dat_w(DATA_W)-1:0]            o_req_vec_dat,
  output logic [ch_w(NCH)-1:0]                o_ch,
  output logic [$clog2(DEPTH):0]              o_count
);

  localparam int BEN_W     = DATA_W / 8;
  localparam int TW        = txn_w(TXNID_W, ADDR_W);
  localparam int DW        = dat_w(DATA_W);
  localparam int CW        = ch_w(NCH);
  localparam int AW        = $clog2(DEPTH);
  localparam int RNW_POS   = rnw_pos(ADDR_W);
  localparam int TXNID_LSB = txnid_lsb(ADDR_W);

  logic [NCH-1:0]     grant;
  logic [CW-1:0]      gidx;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [AW-1:0]      wp;
  logic [AW-1:0]      rp;
  logic [AW:0]        count;

  logic [TXNID_W-1:0] sel_txnid;
  logic               sel_rnw;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [BEN_W-1:0]   sel_ben;
  logic [TW-1:0]      txn_in;
  logic [DW-1:0]      dat_in;

  logic [TW-1:0]      txn_mem [DEPTH];
  logic [DW-1:0]      dat_mem [DEPTH];
  logic [CW-1:0]      ch_mem  [DEPTH];

  vxe_txnreq_rr_arb #(.NCH(NCH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_vld),
    .i_adv   (push),
    .o_grant (grant),
    .o_gidx  (gidx)
  );

  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);
  // No pass-through when full, and nothing is accepted while reset is held.
  assign o_rdy = grant & {NCH{~full & ~rst}};
  assign push  = |o_rdy;
  assign pop   = o_vld & i_rdy;

  always_comb begin
    sel_txnid = '0;
    sel_rnw   = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_ben   = '0;
    for (int c = 0; c < NCH; c++) begin
      if (grant[c]) begin
        sel_txnid = i_txnid[c*TXNID_W +: TXNID_W];
        sel_rnw   = i_rnw[c];
        sel_addr  = i_addr[c*ADDR_W +: ADDR_W];
        sel_data  = i_data[c*DATA_W +: DATA_W];
        sel_ben   = i_ben[c*BEN_W +: BEN_W];
      end
    end
  end

  always_comb begin
    txn_in                   = '0;
    txn_in[ADDR_W-1:0]       = sel_addr;
    txn_in[RNW_POS]          = sel_rnw;
    txn_in[TW-1:TXNID_LSB]   = sel_txnid;
    dat_in                   = sel_rnw ? '0 : {sel_ben, sel_data};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      txn_mem[wp] <= txn_in;
      dat_mem[wp] <= dat_in;
      ch_mem[wp]  <= gidx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign o_vld         = ~empty;
  assign o_count       = count;
  assign o_req_vec_txn = empty ? '0 : txn_mem[rp];
  assign o_req_vec_dat = empty ? '0 : dat_mem[rp];
  assign o_ch          = empty ? '0 : ch_mem[rp];

endmodule

// File: tb/tb_vxe_txnreq_mux_coder.sv
// Directed bench for vxe_txnreq_mux_coder at NCH=2, DEPTH=2: a per-cycle
// vector table plus hand sequences for reset, streaming and mid-run reset.
module tb_vxe_txnreq_mux_coder;

  localparam int NCH     = 2;
  localparam int TXNID_W = 6;
  localparam int ADDR_W  = 37;
  localparam int DATA_W  = 64;
  localparam int BEN_W   = 8;
  localparam int DEPTH   = 2;

  logic                    clk;
  logic                    rst;
  logic [NCH-1:0]          i_vld;
  logic [NCH-1:0]          o_rdy;
  logic [NCH*TXNID_W-1:0]  i_txnid;
  logic [NCH-1:0]          i_rnw;
  logic [NCH*ADDR_W-1:0]   i_addr;
  logic [NCH*DATA_W-1:0]   i_data;
  logic [NCH*BEN_W-1:0]    i_ben;
  logic                    o_vld;
  logic                    i_rdy;
  logic [43:0]             o_req_vec_txn;
  logic [71:0]             o_req_vec_dat;
  logic [0:0]              o_ch;
  logic [1:0]              o_count;

  int checks   = 0;
  int failures = 0;

  vxe_txnreq_mux_coder #(
    .NCH(NCH), .TXNID_W(TXNID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_vld         (i_vld),
    .o_rdy         (o_rdy),
    .i_txnid       (i_txnid),
    .i_rnw         (i_rnw),
    .i_addr        (i_addr),
    .i_data        (i_data),
    .i_ben         (i_ben),
    .o_vld         (o_vld),
    .i_rdy         (i_rdy),
    .o_req_vec_txn (o_req_vec_txn),
    .o_req_vec_dat (o_req_vec_dat),
    .o_ch          (o_ch),
    .o_count       (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] vld;
    logic [1:0] rnw;
    logic       rdy;
    logic [7:0] tag;
    logic [1:0] e_rdy;
    logic       e_vld;
    logic [1:0] e_cnt;
    logic       e_ch;
    logic [7:0] e_tag;
    logic       e_rnw;
  } vec_t;

  vec_t tbl [15];

  // Payload of each channel is derived from a per-cycle tag so heads are traceable.
  function automatic logic [36:0] mk_addr(input logic [7:0] t, input logic c);
    return {1'b1, 20'h0, t, 7'h0, c};
  endfunction

  function automatic logic [63:0] mk_data(input logic [7:0] t, input logic c);
    return {24'hDA7A00, t, 31'h0, c};
  endfunction

  function automatic logic [7:0] mk_ben(input logic [7:0] t);
    return t ^ 8'hA5;
  endfunction

  function automatic logic [43:0] exp_txn(input logic [7:0] t, input logic c, input logic r);
    return {t[5:0], r, mk_addr(t, c)};
  endfunction

  function automatic logic [71:0] exp_dat(input logic [7:0] t, input logic c, input logic r);
    return r ? 72'h0 : {mk_ben(t), mk_data(t, c)};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkHead(input string name, input logic e_vld, input logic [1:0] e_cnt,
                           input logic e_ch, input logic [7:0] e_tag, input logic e_rnw);
    checkOutput({name, ".o_vld"}, 128'(o_vld), 128'(e_vld));
    checkOutput({name, ".o_count"}, 128'(o_count), 128'(e_cnt));
    checkOutput({name, ".o_ch"}, 128'(o_ch), e_vld ? 128'(e_ch) : 128'h0);
    checkOutput({name, ".txn"}, 128'(o_req_vec_txn), e_vld ? 128'(exp_txn(e_tag, e_ch, e_rnw)) : 128'h0);
    checkOutput({name, ".dat"}, 128'(o_req_vec_dat), e_vld ? 128'(exp_dat(e_tag, e_ch, e_rnw)) : 128'h0);
  endtask

  task automatic applyStimulus(input logic [1:0] vld, input logic [1:0] rnw,
                               input logic rdy, input logic [7:0] tag);
    i_vld = vld;
    i_rnw = rnw;
    i_rdy = rdy;
    for (int c = 0; c < NCH; c++) begin
      i_txnid[c*TXNID_W +: TXNID_W] = tag[5:0];
      i_addr[c*ADDR_W +: ADDR_W]    = mk_addr(tag, 1'(c));
      i_data[c*DATA_W +: DATA_W]    = mk_data(tag, 1'(c));
      i_ben[c*BEN_W +: BEN_W]       = mk_ben(tag);
    end
  endtask

  task automatic setCh(input int c, input logic [5:0] id, input logic r,
                       input logic [36:0] a, input logic [63:0] d, input logic [7:0] b);
    i_txnid[c*TXNID_W +: TXNID_W] = id;
    i_rnw[c]                      = r;
    i_addr[c*ADDR_W +: ADDR_W]    = a;
    i_data[c*DATA_W +: DATA_W]    = d;
    i_ben[c*BEN_W +: BEN_W]       = b;
  endtask

  initial begin
    // Columns: vld rnw rdy tag | e_rdy e_vld e_cnt e_ch e_tag e_rnw
    tbl[0]  = '{2'b01, 2'b00, 1'b0, 8'd1,  2'b01, 1'b0, 2'd0, 1'b0, 8'd0,  1'b0};
    tbl[1]  = '{2'b10, 2'b10, 1'b0, 8'd2,  2'b10, 1'b1, 2'd1, 1'b0, 8'd1,  1'b0};
    tbl[2]  = '{2'b11, 2'b00, 1'b0, 8'd3,  2'b00, 1'b1, 2'd2, 1'b0, 8'd1,  1'b0};
    tbl[3]  = '{2'b11, 2'b00, 1'b1, 8'd4,  2'b00, 1'b1, 2'd2, 1'b0, 8'd1,  1'b0};
    tbl[4]  = '{2'b11, 2'b00, 1'b0, 8'd5,  2'b01, 1'b1, 2'd1, 1'b1, 8'd2,  1'b1};
    tbl[5]  = '{2'b11, 2'b00, 1'b1, 8'd6,  2'b00, 1'b1, 2'd2, 1'b1, 8'd2,  1'b1};
    tbl[6]  = '{2'b11, 2'b00, 1'b1, 8'd7,  2'b10, 1'b1, 2'd1, 1'b0, 8'd5,  1'b0};
    tbl[7]  = '{2'b11, 2'b00, 1'b1, 8'd8,  2'b01, 1'b1, 2'd1, 1'b1, 8'd7,  1'b0};
    tbl[8]  = '{2'b11, 2'b00, 1'b1, 8'd9,  2'b10, 1'b1, 2'd1, 1'b0, 8'd8,  1'b0};
    tbl[9]  = '{2'b11, 2'b00, 1'b1, 8'd10, 2'b01, 1'b1, 2'd1, 1'b1, 8'd9,  1'b0};
    tbl[10] = '{2'b00, 2'b00, 1'b1, 8'd11, 2'b00, 1'b1, 2'd1, 1'b0, 8'd10, 1'b0};
    tbl[11] = '{2'b00, 2'b00, 1'b1, 8'd12, 2'b00, 1'b0, 2'd0, 1'b0, 8'd0,  1'b0};
    tbl[12] = '{2'b01, 2'b01, 1'b1, 8'd13, 2'b01, 1'b0, 2'd0, 1'b0, 8'd0,  1'b0};
    tbl[13] = '{2'b00, 2'b00, 1'b1, 8'd14, 2'b00, 1'b1, 2'd1, 1'b0, 8'd13, 1'b1};
    tbl[14] = '{2'b00, 2'b00, 1'b0, 8'd15, 2'b00, 1'b0, 2'd0, 1'b0, 8'd0,  1'b0};

    // Reset with every input driven high.
    rst     = 1'b1;
    i_vld   = '1;
    i_rnw   = '1;
    i_rdy   = 1'b1;
    i_txnid = '1;
    i_addr  = '1;
    i_data  = '1;
    i_ben   = '1;
    @(negedge clk);
    #2;
    checkOutput("reset.o_vld", 128'(o_vld), 128'h0);
    checkOutput("reset.o_rdy", 128'(o_rdy), 128'h0);
    checkOutput("reset.o_count", 128'(o_count), 128'h0);
    checkOutput("reset.txn", 128'(o_req_vec_txn), 128'h0);

    // ch0 write then ch1 read with the literal payloads.
    @(negedge clk);
    rst   = 1'b0;
    i_rdy = 1'b0;
    i_rnw = '0;
    setCh(0, 6'h05, 1'b0, 37'h1000, 64'hDEADBEEF, 8'hFF);
    i_vld = 2'b01;
    #2;
    checkOutput("first.o_rdy", 128'(o_rdy), 128'h1);
    @(negedge clk);
    setCh(1, 6'h09, 1'b1, 37'h2000, 64'h1234, 8'h0F);
    i_vld = 2'b10;
    #2;
    checkOutput("first.o_vld", 128'(o_vld), 128'h1);
    checkOutput("first.txn", 128'(o_req_vec_txn), 128'({6'h05, 1'b0, 37'h1000}));
    checkOutput("first.dat", 128'(o_req_vec_dat), 128'({8'hFF, 64'hDEADBEEF}));
    checkOutput("read.o_rdy", 128'(o_rdy), 128'h2);
    @(negedge clk);
    i_vld = 2'b00;
    i_rdy = 1'b1;
    #2;
    checkOutput("two.o_count", 128'(o_count), 128'h2);
    checkOutput("two.o_ch", 128'(o_ch), 128'h0);
    @(negedge clk);
    #2;
    checkOutput("read.o_ch", 128'(o_ch), 128'h1);
    checkOutput("read.dat", 128'(o_req_vec_dat), 128'h0);
    checkOutput("read.rnw", 128'(o_req_vec_txn[37]), 128'h1);
    checkOutput("read.txn", 128'(o_req_vec_txn), 128'({6'h09, 1'b1, 37'h2000}));
    checkOutput("read.o_count", 128'(o_count), 128'h1);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      applyStimulus(tbl[i].vld, tbl[i].rnw, tbl[i].rdy, tbl[i].tag);
      #2;
      checkOutput($sformatf("vec%0d.o_rdy", i), 128'(o_rdy), 128'(tbl[i].e_rdy));
      checkHead($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_cnt, tbl[i].e_ch,
                tbl[i].e_tag, tbl[i].e_rnw);
    end

    // Back-to-back stream on ch0: count holds at 1 while pointers wrap.
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      applyStimulus(2'b01, 2'b00, 1'b1, 8'(20 + k));
      #2;
      checkOutput($sformatf("stream%0d.o_rdy", k), 128'(o_rdy), 128'h1);
      if (k == 0) checkHead($sformatf("stream%0d", k), 1'b0, 2'd0, 1'b0, 8'd0, 1'b0);
      else        checkHead($sformatf("stream%0d", k), 1'b1, 2'd1, 1'b0, 8'(19 + k), 1'b0);
    end
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 1'b1, 8'd0);
    #2;
    checkHead("stream_tail", 1'b1, 2'd1, 1'b0, 8'd30, 1'b0);
    @(negedge clk);
    #2;
    checkHead("stream_empty", 1'b0, 2'd0, 1'b0, 8'd0, 1'b0);

    // Fill the FIFO, then reset asynchronously between clock edges.
    @(negedge clk);
    applyStimulus(2'b11, 2'b00, 1'b0, 8'd40);
    #2;
    checkOutput("fill0.o_rdy", 128'(o_rdy), 128'h2);
    @(negedge clk);
    applyStimulus(2'b11, 2'b00, 1'b0, 8'd41);
    #2;
    checkOutput("fill1.o_rdy", 128'(o_rdy), 128'h1);
    @(negedge clk);
    applyStimulus(2'b11, 2'b00, 1'b0, 8'd42);
    #2;
    checkOutput("fill.o_count", 128'(o_count), 128'h2);
    checkOutput("fill.o_rdy", 128'(o_rdy), 128'h0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst.o_vld", 128'(o_vld), 128'h0);
    checkOutput("midrst.o_count", 128'(o_count), 128'h0);
    checkOutput("midrst.o_rdy", 128'(o_rdy), 128'h0);
    checkOutput("midrst.txn", 128'(o_req_vec_txn), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'b00, 2'b00, 1'b1, 8'd43);
    #2;
    checkHead("postrst", 1'b0, 2'd0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    applyStimulus(2'b01, 2'b00, 1'b1, 8'd50);
    #2;
    checkOutput("postrst.o_rdy", 128'(o_rdy), 128'h1);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 1'b1, 8'd0);
    #2;
    checkHead("postrst_new", 1'b1, 2'd1, 1'b0, 8'd50, 1'b0);
    @(negedge clk);
    #2;
    checkHead("postrst_drained", 1'b0, 2'd0, 1'b0, 8'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vxe_txnreq_mux_coder.md
# vxe_txnreq_mux_coder

Parametrised request-transaction coder that merges NCH independent request channels into one encoded request stream. Round-robin arbitration selects a channel, and the request is packed into transaction and data vectors. The result is buffered in a DEPTH-entry FIFO with a valid/ready output handshake. Sits between the VxE client request ports and the memory-interface request path.

## Interface
Parameters:
- NCH, 2: number of request channels, 1..8.
- TXNID_W, 6: transaction-id width.
- ADDR_W, 37: address width (upper bits of the byte address).
- DATA_W, 64: write-data width. BEN_W = DATA_W/8 is derived.
- DEPTH, 2: output FIFO entries, power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_vld  in  NCH  per-channel request valid.
- o_rdy  out  NCH  per-channel request accepted this cycle.
- i_txnid  in  NCH*TXNID_W  per-channel transaction id; channel c occupies slice c.
- i_rnw  in  NCH  1 = read, 0 = write.
- i_addr  in  NCH*ADDR_W  per-channel address.
- i_data  in  NCH*DATA_W  per-channel write data.
- i_ben  in  NCH*BEN_W  per-channel byte enables.
- o_vld  out  1  FIFO head valid.
- i_rdy  in  1  downstream accepts head.
- o_req_vec_txn  out  TXNID_W+1+ADDR_W  {txnid, rnw, addr} of head.
- o_req_vec_dat  out  BEN_W+DATA_W  {ben, data} of head.
- o_ch  out  clog2(max(NCH,2))  source channel of head.
- o_count  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Arbiter: the rotating priority pointer `ptr` (reset 0) names the highest-priority channel. The grant goes to the first channel c with i_vld[c] set, searching ptr, ptr+1, … modulo NCH.
- o_rdy[c] = grant[c] & ~full. This path is combinational from i_vld. At most one o_rdy bit is set per cycle.
- Push: i_vld[c] & o_rdy[c]. Write the encoded entry at `wp` and increment wp modulo DEPTH. Set ptr to (c+1) mod NCH.
- No push means ptr holds its value. With NCH=1, ptr stays 0.
- Encoding: txn = {txnid, rnw, addr}.
- Read requests (rnw=1) store dat = 0: ben and data are both forced to zero. Writes store {ben, data} unchanged.
- Pop: o_vld & i_rdy. Increment rp modulo DEPTH.
- Occupancy: count += push − pop. full = (count == DEPTH). empty = (count == 0). o_vld = ~empty.
- Simultaneous push and pop: allowed whenever not full. count is unchanged.
- When full, no push occurs in that cycle, even if a pop also occurs (no pass-through). o_rdy is all-zero.
- When empty, no bypass is made: a pushed entry first appears on the output the cycle after acceptance.
- Output fields are driven from the entry at rp. o_req_vec_txn, o_req_vec_dat and o_ch read as 0 when empty.
- Inputs on non-granted channels are ignored. Input payload must be stable only in the accept cycle.

## Timing
- Reset values: o_vld=0, o_count=0, o_rdy=0 (combinational, and forced 0 during rst), o_req_vec_txn=0, o_req_vec_dat=0, o_ch=0, ptr=0, wp=rp=0.
- Reset asserted mid-operation discards all FIFO contents immediately (asynchronous reset).
- Latency is 1 cycle from accept to o_vld.
- Throughput is one request per cycle while i_rdy stays high.
- Once o_vld is asserted, the head must not change until popped (the downstream handshake is AXI-style).
- o_count updates on the clock edge after a push or pop.
- Wrap-around: wp and rp roll from DEPTH−1 to 0. count distinguishes full from empty.

## Structure
- Shared package vxe_txn_pkg holds:
  - TXNID_W, ADDR_W and DATA_W defaults;
  - txn and dat vector width functions;
  - field offsets (addr at [ADDR_W-1:0], rnw at ADDR_W, txnid above it).
- Sub-module vxe_txnreq_rr_arb holds the NCH-way round-robin arbiter. Its interface is i_req, i_adv, o_grant, o_gidx, with the pointer register kept inside.
- The FIFO is inline: register array and pointers.

## Test plan
- Reset with all inputs high → o_vld=0, o_rdy=0, o_count=0. After rst falls, ch0 write (txnid 0x05, addr 0x1000, data 0xDEADBEEF, ben 0xFF) → o_rdy=01. Next cycle: o_vld=1 and o_req_vec_txn={0x05, 0, 0x1000}.
- Read on ch1 with data 0x1234 and ben 0x0F → o_req_vec_dat = 0 and rnw bit = 1.
- Both channels hold i_vld for 4 cycles with i_rdy=1 → grants are 0,1,0,1 and o_ch follows one cycle later.
- i_rdy=0 with DEPTH=2: two pushes, then o_rdy=00 and o_count=2. Raising i_rdy gives a pop; push resumes the following cycle and order is preserved.
- Continuous push and pop for 10 cycles → o_count stays 1, wp and rp wrap, and no entry is lost or duplicated.
- Assert rst while o_count=2 → outputs reach reset values before the next clk edge, and the old entries never appear.
